// File: rtl/axil_pkg.sv
// Shared types and address decode for the AXI4-Lite 1-to-2 splitter.
package axil_pkg;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} rd_state_t;

  localparam logic [31:0] AXIL_S1_BASE = 32'h1000_0000;
  localparam logic [31:0] AXIL_S1_MASK = 32'hF000_0000;

  // Returns 1 when the address falls inside the S1 window; S0 is the default slave.
  function automatic logic axil_decode(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/axil_split.sv
// 1-to-2 AXI4-Lite address splitter: one initiator, two responders (S0 default, S1 window).
// One outstanding write and one outstanding read, routed independently.
module axil_split
  import axil_pkg::*;
#(
  parameter logic [31:0] S1_BASE = AXIL_S1_BASE,
  parameter logic [31:0] S1_MASK = AXIL_S1_MASK
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        M_AWVALID,
  input  logic [31:0] M_AWADDR,
  output logic        M_AWREADY,
  input  logic        M_WVALID,
  input  logic [31:0] M_WDATA,
  input  logic [3:0]  M_WSTRB,
  output logic        M_WREADY,
  output logic        M_BVALID,
  input  logic        M_BREADY,
  input  logic        M_ARVALID,
  input  logic [31:0] M_ARADDR,
  output logic        M_ARREADY,
  output logic        M_RVALID,
  output logic [31:0] M_RDATA,
  input  logic        M_RREADY,
  output logic        S0_AWVALID,
  output logic [31:0] S0_AWADDR,
  input  logic        S0_AWREADY,
  output logic        S0_WVALID,
  output logic [31:0] S0_WDATA,
  output logic [3:0]  S0_WSTRB,
  input  logic        S0_WREADY,
  input  logic        S0_BVALID,
  output logic        S0_BREADY,
  output logic        S0_ARVALID,
  output logic [31:0] S0_ARADDR,
  input  logic        S0_ARREADY,
  input  logic        S0_RVALID,
  input  logic [31:0] S0_RDATA,
  output logic        S0_RREADY,
  output logic        S1_AWVALID,
  output logic [31:0] S1_AWADDR,
  input  logic        S1_AWREADY,
  output logic        S1_WVALID,
  output logic [31:0] S1_WDATA,
  output logic [3:0]  S1_WSTRB,
  input  logic        S1_WREADY,
  input  logic        S1_BVALID,
  output logic        S1_BREADY,
  output logic        S1_ARVALID,
  output logic [31:0] S1_ARADDR,
  input  logic        S1_ARREADY,
  input  logic        S1_RVALID,
  input  logic [31:0] S1_RDATA,
  output logic        S1_RREADY
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic wsel, wsel_next, rsel, rsel_next;
  logic aw_done, aw_done_next, w_done, w_done_next;
  logic aw_fwd, w_fwd, b_fwd, ar_fwd, r_fwd;
  logic aw_hs, w_hs;

  logic sel_awready, sel_wready, sel_bvalid, sel_arready, sel_rvalid;

  assign sel_awready = wsel ? S1_AWREADY : S0_AWREADY;
  assign sel_wready  = wsel ? S1_WREADY  : S0_WREADY;
  assign sel_bvalid  = wsel ? S1_BVALID  : S0_BVALID;
  assign sel_arready = rsel ? S1_ARREADY : S0_ARREADY;
  assign sel_rvalid  = rsel ? S1_RVALID  : S0_RVALID;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wsel     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      wsel     <= wsel_next;
      aw_done  <= aw_done_next;
      w_done   <= w_done_next;
    end
  end

  // AW and W may complete in either order; the done flags stop a second beat on either channel.
  always_comb begin
    wr_next      = wr_state;
    wsel_next    = wsel;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    aw_fwd       = 1'b0;
    w_fwd        = 1'b0;
    b_fwd        = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    M_AWREADY    = 1'b0;
    M_WREADY     = 1'b0;
    M_BVALID     = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (M_AWVALID) begin
          wsel_next = axil_decode(M_AWADDR, S1_BASE, S1_MASK);
          wr_next   = W_FWD;
        end
      end
      W_FWD: begin
        aw_fwd    = M_AWVALID & ~aw_done;
        w_fwd     = M_WVALID & ~w_done;
        M_AWREADY = sel_awready & ~aw_done;
        M_WREADY  = sel_wready & ~w_done;
        aw_hs     = aw_fwd & sel_awready;
        w_hs      = w_fwd & sel_wready;
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          wr_next      = W_RESP;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          aw_done_next = aw_done | aw_hs;
          w_done_next  = w_done | w_hs;
        end
      end
      W_RESP: begin
        M_BVALID = sel_bvalid;
        b_fwd    = M_BREADY;
        if (sel_bvalid & M_BREADY) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rsel     <= 1'b0;
    end else begin
      rd_state <= rd_next;
      rsel     <= rsel_next;
    end
  end

  always_comb begin
    rd_next   = rd_state;
    rsel_next = rsel;
    ar_fwd    = 1'b0;
    r_fwd     = 1'b0;
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (M_ARVALID) begin
          rsel_next = axil_decode(M_ARADDR, S1_BASE, S1_MASK);
          rd_next   = R_FWD;
        end
      end
      R_FWD: begin
        ar_fwd    = M_ARVALID;
        M_ARREADY = sel_arready;
        if (M_ARVALID & sel_arready) rd_next = R_RESP;
      end
      R_RESP: begin
        M_RVALID = sel_rvalid;
        r_fwd    = M_RREADY;
        if (sel_rvalid & M_RREADY) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Only the selected slave ever sees a VALID or READY; addresses and data are broadcast.
  assign S0_AWVALID = aw_fwd & ~wsel;
  assign S1_AWVALID = aw_fwd & wsel;
  assign S0_WVALID  = w_fwd & ~wsel;
  assign S1_WVALID  = w_fwd & wsel;
  assign S0_BREADY  = b_fwd & ~wsel;
  assign S1_BREADY  = b_fwd & wsel;
  assign S0_ARVALID = ar_fwd & ~rsel;
  assign S1_ARVALID = ar_fwd & rsel;
  assign S0_RREADY  = r_fwd & ~rsel;
  assign S1_RREADY  = r_fwd & rsel;

  assign S0_AWADDR = M_AWADDR;
  assign S1_AWADDR = M_AWADDR;
  assign S0_WDATA  = M_WDATA;
  assign S1_WDATA  = M_WDATA;
  assign S0_WSTRB  = M_WSTRB;
  assign S1_WSTRB  = M_WSTRB;
  assign S0_ARADDR = M_ARADDR;
  assign S1_ARADDR = M_ARADDR;
  assign M_RDATA   = rsel ? S1_RDATA : S0_RDATA;

endmodule

// File: tb/tb_axil_split.sv
// Scoreboard bench for axil_split: directed master transactions, behavioural slaves,
// and a negedge monitor checking slave-side beats and master-side responses.
module tb_axil_split;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  st;
  } beat_t;

  logic clock = 1'b0;
  logic reset, slave_reset;

  logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
  logic [3:0]  M_WSTRB;
  wire         M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID;
  wire  [31:0] M_RDATA;

  wire s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid, s0_bready, s1_bready;
  wire s0_arvalid, s1_arvalid, s0_rready, s1_rready;
  wire [31:0] s0_awaddr, s1_awaddr, s0_wdata, s1_wdata, s0_araddr, s1_araddr;
  wire [3:0]  s0_wstrb, s1_wstrb;

  logic [1:0]  awrdy, wrdy, arrdy, bvld, rvld;
  logic [1:0]  got_aw, got_w;
  logic [31:0] rdat0, rdat1;

  wire [1:0] awv  = {s1_awvalid, s0_awvalid};
  wire [1:0] wv   = {s1_wvalid, s0_wvalid};
  wire [1:0] arv  = {s1_arvalid, s0_arvalid};
  wire [1:0] brdy = {s1_bready, s0_bready};
  wire [1:0] rrdy = {s1_rready, s0_rready};

  int total = 0;
  int bad = 0;

  beat_t exp_aw[$];
  beat_t exp_w[$];
  beat_t exp_ar[$];
  bit    exp_b[$];
  logic [31:0] exp_r[$];

  axil_split dut (
    .clock(clock), .reset(reset),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WREADY(M_WREADY),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .M_ARREADY(M_ARREADY),
    .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .M_RREADY(M_RREADY),
    .S0_AWVALID(s0_awvalid), .S0_AWADDR(s0_awaddr), .S0_AWREADY(awrdy[0]),
    .S0_WVALID(s0_wvalid), .S0_WDATA(s0_wdata), .S0_WSTRB(s0_wstrb), .S0_WREADY(wrdy[0]),
    .S0_BVALID(bvld[0]), .S0_BREADY(s0_bready),
    .S0_ARVALID(s0_arvalid), .S0_ARADDR(s0_araddr), .S0_ARREADY(arrdy[0]),
    .S0_RVALID(rvld[0]), .S0_RDATA(rdat0), .S0_RREADY(s0_rready),
    .S1_AWVALID(s1_awvalid), .S1_AWADDR(s1_awaddr), .S1_AWREADY(awrdy[1]),
    .S1_WVALID(s1_wvalid), .S1_WDATA(s1_wdata), .S1_WSTRB(s1_wstrb), .S1_WREADY(wrdy[1]),
    .S1_BVALID(bvld[1]), .S1_BREADY(s1_bready),
    .S1_ARVALID(s1_arvalid), .S1_ARADDR(s1_araddr), .S1_ARREADY(arrdy[1]),
    .S1_RVALID(rvld[1]), .S1_RDATA(rdat1), .S1_RREADY(s1_rready)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural slaves: B one cycle after both AW and W land, R one cycle after AR.
  always @(posedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (slave_reset) begin
        got_aw[s] <= 1'b0;
        got_w[s]  <= 1'b0;
        bvld[s]   <= 1'b0;
        rvld[s]   <= 1'b0;
      end else begin
        if (awv[s] && awrdy[s]) got_aw[s] <= 1'b1;
        if (wv[s] && wrdy[s]) got_w[s] <= 1'b1;
        if (bvld[s] && brdy[s]) bvld[s] <= 1'b0;
        else if (got_aw[s] && got_w[s] && !bvld[s]) begin
          bvld[s]   <= 1'b1;
          got_aw[s] <= 1'b0;
          got_w[s]  <= 1'b0;
        end
        if (arv[s] && arrdy[s]) rvld[s] <= 1'b1;
        else if (rvld[s] && rrdy[s]) rvld[s] <= 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and watches routing and stall stability.
  logic [1:0]       prev_arv, prev_arrdy;
  logic [1:0][31:0] prev_araddr;
  logic             prev_mbv, prev_mbr;

  always @(negedge clock) begin
    beat_t e;
    logic [31:0] rd;
    if (!reset) begin
      checkOutput("xtalk", {59'd0, awv == 2'b11, wv == 2'b11, arv == 2'b11,
                            brdy == 2'b11, rrdy == 2'b11}, 64'd0);
      for (int s = 0; s < 2; s++) begin
        if (awv[s] && awrdy[s]) begin
          if (exp_aw.size() == 0) checkOutput("aw_unexpected", 1, 0);
          else begin
            e = exp_aw.pop_front();
            checkOutput("aw_slave", s, e.s);
            checkOutput("aw_addr", s ? s1_awaddr : s0_awaddr, e.a);
          end
        end
        if (wv[s] && wrdy[s]) begin
          if (exp_w.size() == 0) checkOutput("w_unexpected", 1, 0);
          else begin
            e = exp_w.pop_front();
            checkOutput("w_slave", s, e.s);
            checkOutput("w_data", {s ? s1_wstrb : s0_wstrb, s ? s1_wdata : s0_wdata}, {e.st, e.d});
          end
        end
        if (arv[s] && arrdy[s]) begin
          if (exp_ar.size() == 0) checkOutput("ar_unexpected", 1, 0);
          else begin
            e = exp_ar.pop_front();
            checkOutput("ar_slave", s, e.s);
            checkOutput("ar_addr", s ? s1_araddr : s0_araddr, e.a);
          end
        end
        if (prev_arv[s] && !prev_arrdy[s])
          checkOutput("arvalid_hold", {arv[s], s ? s1_araddr : s0_araddr}, {1'b1, prev_araddr[s]});
      end
      if (M_BVALID && M_BREADY) begin
        checkOutput("b_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) void'(exp_b.pop_front());
      end
      if (prev_mbv && !prev_mbr) checkOutput("bvalid_hold", M_BVALID, 1);
      if (M_RVALID && M_RREADY) begin
        if (exp_r.size() == 0) checkOutput("r_unexpected", 1, 0);
        else begin
          rd = exp_r.pop_front();
          checkOutput("r_data", M_RDATA, rd);
        end
      end
    end
    prev_arv       <= arv;
    prev_arrdy     <= arrdy;
    prev_araddr[0] <= s0_araddr;
    prev_araddr[1] <= s1_araddr;
    prev_mbv       <= M_BVALID;
    prev_mbr       <= M_BREADY;
  end

  // lead > 0: W raised that many cycles before AW; lead < 0: AW first.
  task automatic sendAwW(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int lead);
    int  k = 0;
    bit  aw_left = 1'b1;
    bit  w_left = 1'b1;
    int  aw_start = (lead > 0) ? lead : 0;
    int  w_start = (lead < 0) ? -lead : 0;
    M_AWADDR = addr;
    M_WDATA  = data;
    M_WSTRB  = strb;
    while ((aw_left || w_left) && k < 60) begin
      M_AWVALID = aw_left && (k >= aw_start);
      M_WVALID  = w_left && (k >= w_start);
      @(negedge clock);
      if (M_AWVALID && M_AWREADY) aw_left = 1'b0;
      if (M_WVALID && M_WREADY) w_left = 1'b0;
      @(posedge clock);
      #1;
      k++;
    end
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    if (aw_left || w_left) checkOutput("aw_w_timeout", {aw_left, w_left}, 0);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit exp_s,
                               input int lead, input int b_stall);
    int n = 0;
    bit hs = 1'b0;
    exp_aw.push_back('{s: exp_s, a: addr, d: 32'd0, st: 4'd0});
    exp_w.push_back('{s: exp_s, a: 32'd0, d: data, st: strb});
    exp_b.push_back(exp_s);
    M_BREADY = 1'b0;
    sendAwW(addr, data, strb, lead);
    repeat (b_stall) begin
      @(posedge clock);
      #1;
    end
    M_BREADY = 1'b1;
    do begin
      @(negedge clock);
      hs = M_BVALID && M_BREADY;
      @(posedge clock);
      #1;
      n++;
    end while (!hs && n < 50);
    M_BREADY = 1'b0;
    if (!hs) checkOutput("b_timeout", 0, 1);
  endtask

  task automatic readTxn(input logic [31:0] addr, input bit exp_s, input logic [31:0] exp_data);
    int n = 0;
    bit hs = 1'b0;
    exp_ar.push_back('{s: exp_s, a: addr, d: 32'd0, st: 4'd0});
    exp_r.push_back(exp_data);
    M_ARADDR  = addr;
    M_ARVALID = 1'b1;
    M_RREADY  = 1'b1;
    do begin
      @(negedge clock);
      hs = M_ARVALID && M_ARREADY;
      @(posedge clock);
      #1;
      n++;
    end while (!hs && n < 50);
    M_ARVALID = 1'b0;
    if (!hs) checkOutput("ar_timeout", 0, 1);
    hs = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      hs = M_RVALID && M_RREADY;
      @(posedge clock);
      #1;
      n++;
    end while (!hs && n < 50);
    M_RREADY = 1'b0;
    if (!hs) checkOutput("r_timeout", 0, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; slave_reset = 1'b1;
    M_AWVALID = 1'b1; M_WVALID = 1'b1; M_ARVALID = 1'b1;
    M_BREADY = 1'b1; M_RREADY = 1'b1;
    M_AWADDR = 32'h1000_0000; M_ARADDR = 32'h1000_0000;
    M_WDATA = 32'd0; M_WSTRB = 4'd0;
    awrdy = 2'b11; wrdy = 2'b11; arrdy = 2'b11;
    rdat0 = 32'h0BAD_0000; rdat1 = 32'h1234_5678;

    // Valids held high during reset must not leak into either FSM.
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput("reset_outputs", {M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID,
                                    awv, wv, arv, brdy, rrdy}, 64'd0);
    end
    @(posedge clock);
    #1;
    M_AWVALID = 1'b0; M_WVALID = 1'b0; M_ARVALID = 1'b0;
    M_BREADY = 1'b0; M_RREADY = 1'b0;
    reset = 1'b0; slave_reset = 1'b0;
    @(posedge clock);
    #1;

    applyStimulus(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, 0);
    readTxn(32'h1000_0010, 1'b1, 32'h1234_5678);
    applyStimulus(32'h0000_0044, 32'h0102_0304, 4'h5, 1'b0, 2, 0);
    applyStimulus(32'h1000_0048, 32'hA0B0_C0D0, 4'hA, 1'b1, 0, 0);
    applyStimulus(32'h1000_004C, 32'h5555_AAAA, 4'h8, 1'b1, -2, 0);

    fork
      applyStimulus(32'h0000_0200, 32'h0BAD_F00D, 4'hC, 1'b0, 0, 0);
      readTxn(32'h1000_0030, 1'b1, 32'h1234_5678);
    join
    rdat1 = 32'h7777_0001;
    fork
      applyStimulus(32'h1000_0040, 32'h0000_FFFF, 4'h3, 1'b1, 0, 1);
      readTxn(32'h1000_0044, 1'b1, 32'h7777_0001);
    join

    applyStimulus(32'h1FFF_FFFF, 32'h1111_2222, 4'h1, 1'b1, 0, 0);
    readTxn(32'h1000_0000, 1'b1, 32'h7777_0001);
    readTxn(32'h2000_0000, 1'b0, 32'h0BAD_0000);
    readTxn(32'h0FFF_FFFC, 1'b0, 32'h0BAD_0000);
    applyStimulus(32'h9000_0000, 32'h3333_4444, 4'hF, 1'b0, 0, 0);

    // Slave stalls: S1 ARREADY low for 5 cycles, then a write whose B is held off 3 cycles.
    rdat1 = 32'hA5A5_0F0F;
    arrdy[1] = 1'b0;
    fork
      readTxn(32'h1000_0020, 1'b1, 32'hA5A5_0F0F);
      begin
        repeat (5) @(posedge clock);
        #1 arrdy[1] = 1'b1;
      end
    join
    applyStimulus(32'h0000_0100, 32'hFEED_FACE, 4'hF, 1'b0, 0, 3);

    // Reset in W_RESP while S0 still presents BVALID; the slave is deliberately kept out of reset.
    exp_aw.push_back('{s: 1'b0, a: 32'h0000_0080, d: 32'd0, st: 4'd0});
    exp_w.push_back('{s: 1'b0, a: 32'd0, d: 32'hCAFE_0001, st: 4'h3});
    M_BREADY = 1'b0;
    sendAwW(32'h0000_0080, 32'hCAFE_0001, 4'h3, 0);
    n = 0;
    while (!bvld[0] && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    @(negedge clock);
    checkOutput("bvalid_before_reset", {bvld[0], M_BVALID}, 2'b11);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("reset_in_wresp", {bvld[0], M_BVALID, M_AWREADY, M_WREADY, s0_bready}, 5'b10000);
    @(posedge clock);
    #1 reset = 1'b0;
    M_BREADY = 1'b1;
    repeat (2) begin
      @(negedge clock);
      checkOutput("idle_ignores_b", {M_BVALID, s0_bready}, 2'b00);
      @(posedge clock);
      #1;
    end
    M_BREADY = 1'b0;
    slave_reset = 1'b1;
    @(posedge clock);
    #1 slave_reset = 1'b0;

    applyStimulus(32'h0000_0300, 32'h8765_4321, 4'hF, 1'b0, 0, 0);

    repeat (4) @(posedge clock);
    checkOutput("aw_left", exp_aw.size(), 0);
    checkOutput("w_left", exp_w.size(), 0);
    checkOutput("ar_left", exp_ar.size(), 0);
    checkOutput("b_left", exp_b.size(), 0);
    checkOutput("r_left", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
